instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage that sits directly upstream of instr_memory. It owns the fetch PC and drives the
//  instruction memory address. Each fetched {pc, instr} pair is buffered in a small prefetch FIFO
//  and handed to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and
//  reload the PC.
// PARAMETERS
//  NUM_INSTR   32  words in instr_memory; ADDR_W = $clog2(NUM_INSTR*4), byte addressed
//  FIFO_DEPTH  4   prefetch entries; power of two, >= 2
//  RESET_PC    0   fetch PC value loaded on reset
// PORTS
//  clk             in   1       clock; all state updates on the rising edge
//  rstn            in   1       reset, synchronous, active-low
//  imem_addr       out  ADDR_W  byte address to instr_memory = fetch_pc[ADDR_W-1:0]
//  imem_instr      in   32      instruction word from instr_memory; combinational read, same cycle
//  redirect_valid  in   1       branch/jump taken; flush the buffer and load redirect_pc
//  redirect_pc     in   32      new fetch PC; bits [1:0] are ignored (treated as 0)
//  out_valid       out  1       FIFO head holds a valid entry
//  out_ready       in   1       decode accepts the head entry when out_valid && out_ready
//  out_pc          out  32      PC of the head entry
//  out_instr       out  32      instruction of the head entry
//  occupancy       out  $clog2(FIFO_DEPTH)+1  number of buffered entries
// BEHAVIOUR
//  - Reset (rstn == 0 at a clock edge): fetch_pc <= RESET_PC, FIFO emptied.
//    out_valid = 0, occupancy = 0, imem_addr = RESET_PC[ADDR_W-1:0]. Reset overrides all other inputs.
//  - pop  = out_valid && out_ready && !redirect_valid
//  - push = !redirect_valid && (occupancy < FIFO_DEPTH || pop)
//  - A push writes {fetch_pc, imem_instr} at the tail and advances fetch_pc by 4.
//  - With no push, fetch_pc holds and imem_addr stays stable.
//  - Full FIFO with a simultaneous pop: push and pop occur in the same cycle; occupancy unchanged.
//  - Empty FIFO: out_valid = 0. out_ready is ignored. A push still occurs.
//  - There is no bypass. An entry pushed in cycle N is visible at out_* in cycle N+1.
//    First out_valid is in the 2nd cycle after rstn rises; fetch-to-decode latency is 1 cycle.
//  - Redirect: in the cycle redirect_valid = 1, out_valid is forced to 0 and no pop occurs.
//    At the edge: FIFO cleared, fetch_pc <= {redirect_pc[31:2], 2'b00}, no push.
//    First post-redirect entry appears 2 cycles after the redirect edge.
//  - Back-to-back redirects: each one reloads fetch_pc; the last one wins.
//  - out_pc/out_instr are don't-care while out_valid = 0. They must remain stable while
//    out_valid && !out_ready (AXI-style hold).
//  - Arithmetic: fetch_pc is 32 bits and wraps modulo 2^32. imem_addr truncates to ADDR_W bits,
//    so fetches wrap at NUM_INSTR*4 bytes; out_pc keeps the full 32-bit value.
//  - FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. occupancy is kept as an
//    explicit counter.
// STRUCTURE
//  - rv32i_defs gains:
//      typedef struct packed {logic [31:0] pc; logic [InstructionSize-1:0] instr;} fetch_entry_t;
//      localparam int PcStep = 4;
//  - Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, occupancy
//    and head output. Flush takes priority over push/pop.
//  - Top level: PC register, push/pop/redirect control, address truncation.
// TESTING  (imem loaded with the core test image: word0=0x00500113, word1=0x00C00193,
//           word2=0xFF718393)
//  1 Reset release, out_ready=1:
//    -> cycle 1: out_valid=1, out_pc=0, out_instr=0x00500113; cycle 2: pc=4, 0x00C00193;
//       one entry per cycle thereafter.
//  2 out_ready=0 for 6 cycles:
//    -> occupancy saturates at 4, fetch_pc holds at 0x10, head stays pc=0/0x00500113.
//    Raise out_ready -> entries pc 0,4,8,0xC delivered in order, no gaps or duplicates.
//  3 Full FIFO, out_ready=1 held:
//    -> simultaneous push/pop each cycle, occupancy stays 4, out_pc increments by 4 per cycle.
//  4 redirect_valid=1, redirect_pc=0x0000_0009 while 3 entries are buffered:
//    -> same cycle out_valid=0; next cycle occupancy=0;
//    -> following cycle out_pc=8, out_instr=0xFF718393.
//  5 Wrap: redirect_pc=0x7C (NUM_INSTR=32)
//    -> entries with out_pc 0x7C then 0x80; the 0x80 entry carries word0 (imem_addr=0).
//  6 rstn=0 for one cycle mid-stream with 3 entries buffered
//    -> next cycle out_valid=0, occupancy=0, imem_addr=0; refetch starts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared types and constants for the fetch stage.
//   Contents:
//     InstructionSize  width of one instruction word
//     PcStep           byte distance between consecutive instruction words
//     fetch_entry_t    one buffered {pc, instr} pair as handed to decode
//     alignPc()        forces a PC onto a word boundary
// ----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

   localparam int InstructionSize = 32;
   localparam int PcStep          = 4;

   typedef struct packed {
      logic [31:0]                pc;
      logic [InstructionSize-1:0] instr;
   } fetch_entry_t;

   // Redirect targets may carry stray low bits; the fetch PC is always word aligned.
   function automatic logic [31:0] alignPc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the instruction-memory port, the redirect input and the decode
//   handshake of the fetch stage.
//   master : the fetch unit (drives imem_addr, out_*, occupancy)
//   slave  : the environment (memory, branch unit, decode)
//   Signals:
//     imem_addr      byte address to instruction memory
//     imem_instr     instruction word returned combinationally
//     redirect_valid branch/jump taken
//     redirect_pc    new fetch target
//     out_valid      head entry valid
//     out_ready      decode accepts the head entry
//     out_pc         PC of the head entry
//     out_instr      instruction of the head entry
//     occupancy      number of buffered entries
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int NUM_INSTR  = 32,
   parameter int FIFO_DEPTH = 4
);

   localparam int ADDR_W = $clog2(NUM_INSTR * 4);
   localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;

   logic [ADDR_W-1:0]          imem_addr;
   logic [InstructionSize-1:0] imem_instr;
   logic                       redirect_valid;
   logic [31:0]                redirect_pc;
   logic                       out_valid;
   logic                       out_ready;
   logic [31:0]                out_pc;
   logic [InstructionSize-1:0] out_instr;
   logic [OCC_W-1:0]           occupancy;

   modport master (
      output imem_addr, out_valid, out_pc, out_instr, occupancy,
      input  imem_instr, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_pc, out_instr, occupancy,
      output imem_instr, redirect_valid, redirect_pc, out_ready
   );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous prefetch FIFO of fetch_entry_t. Flush wins over push/pop.
//   Ports:
//     clk          clock
//     rstn         synchronous active-low reset (empties the FIFO)
//     push_i       write data_i at the tail
//     pop_i        retire the head entry
//     flush_i      discard all entries
//     data_i       entry to write
//     head_o       entry at the head (don't-care while valid_o = 0)
//     valid_o      head holds a valid entry
//     occupancy_o  number of buffered entries
// ----------------------------------------------------------------------------
module fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  fetch_entry_t               data_i,
   output fetch_entry_t               head_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     occupancy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   fetch_entry_t      memQ [DEPTH];
   logic [PTR_W-1:0]  wrPtrQ, wrPtrD;
   logic [PTR_W-1:0]  rdPtrQ, rdPtrD;
   logic [OCC_W-1:0]  countQ, countD;
   logic              pushOk;
   logic              popOk;

   // A push into a full FIFO is only legal when the head leaves in the same
   // cycle; a pop from an empty FIFO is simply dropped.
   assign popOk  = pop_i && (countQ != '0);
   assign pushOk = push_i && ((countQ < OCC_W'(DEPTH)) || popOk);

   // Next-state for pointers and the explicit occupancy counter. Pointers are
   // exactly log2(DEPTH) bits so they wrap without any compare.
   always_comb begin
      wrPtrD = wrPtrQ;
      rdPtrD = rdPtrQ;
      countD = countQ;
      if (flush_i) begin
         wrPtrD = '0;
         rdPtrD = '0;
         countD = '0;
      end else begin
         if (pushOk) wrPtrD = wrPtrQ + PTR_W'(1);
         if (popOk)  rdPtrD = rdPtrQ + PTR_W'(1);
         if (pushOk && !popOk)      countD = countQ + OCC_W'(1);
         else if (popOk && !pushOk) countD = countQ - OCC_W'(1);
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wrPtrQ <= '0;
         rdPtrQ <= '0;
         countQ <= '0;
      end else begin
         wrPtrQ <= wrPtrD;
         rdPtrQ <= rdPtrD;
         countQ <= countD;
      end
   end

   // Storage needs no reset: an entry is only visible once the counter covers it.
   always_ff @(posedge clk) begin
      if (pushOk && !flush_i) begin
         memQ[wrPtrQ] <= data_i;
      end
   end

   assign head_o      = memQ[rdPtrQ];
   assign valid_o     = (countQ != '0);
   assign occupancy_o = countQ;

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage upstream of instr_memory. Owns the fetch PC, drives the memory
//   address, buffers {pc, instr} pairs in a prefetch FIFO and hands them to
//   decode over valid/ready. A redirect flushes the buffer and reloads the PC.
//   Ports:
//     clk    clock
//     rstn   synchronous active-low reset
//     bus    instr_fetch_unit_if.master (imem port, redirect, decode handshake)
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          NUM_INSTR  = 32,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rstn,
   instr_fetch_unit_if.master     bus
);

   localparam int ADDR_W = $clog2(NUM_INSTR * 4);
   localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      pcQ, pcD;
   logic             push;
   logic             pop;
   logic             headValid;
   fetch_entry_t     headEntry;
   fetch_entry_t     pushEntry;
   logic [OCC_W-1:0] occ;

   // A redirect suppresses both ends of the buffer for that cycle. Push needs
   // room, but a full FIFO can still accept when the head leaves simultaneously.
   assign pop  = headValid && bus.out_ready && !bus.redirect_valid;
   assign push = !bus.redirect_valid && ((occ < OCC_W'(FIFO_DEPTH)) || pop);

   assign pushEntry.pc    = pcQ;
   assign pushEntry.instr = bus.imem_instr;

   // Next fetch PC: redirect target, sequential step on a push, otherwise hold
   // so the memory address stays stable while the buffer is stalled.
   always_comb begin
      pcD = pcQ;
      if (bus.redirect_valid) begin
         pcD = alignPc(bus.redirect_pc);
      end else if (push) begin
         pcD = pcQ + 32'(PcStep);
      end
   end

   // Fetch PC register; wraps modulo 2^32 through plain addition.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pcQ <= RESET_PC;
      end else begin
         pcQ <= pcD;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .push_i      (push),
      .pop_i       (pop),
      .flush_i     (bus.redirect_valid),
      .data_i      (pushEntry),
      .head_o      (headEntry),
      .valid_o     (headValid),
      .occupancy_o (occ)
   );

   // Truncation makes fetches wrap at NUM_INSTR*4 bytes; out_pc keeps all 32 bits.
   assign bus.imem_addr = pcQ[ADDR_W-1:0];
   assign bus.out_valid = headValid && !bus.redirect_valid;
   assign bus.out_pc    = headEntry.pc;
   assign bus.out_instr = headEntry.instr;
   assign bus.occupancy = occ;

endmodule
